// File: rtl/multi_bank_ram_arbiter.sv
// BANK_NO-way banked dual-port RAM; reads return READ_LATENCY cycles after acceptance via a tag-steered output mux.
// Backpressure: ready drops only for the non-priority port on a same-address hazard involving a write; held requests retry.
module multi_bank_ram_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 3,
    parameter int BANK_NO      = 4,
    parameter int INTERLEAVE   = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_ena,
    input  logic                  i_wea,
    input  logic [ADDR_WIDTH-1:0] i_addra,
    input  logic [DATA_WIDTH-1:0] i_dina,
    output logic                  o_readya,
    output logic [DATA_WIDTH-1:0] o_douta,
    output logic                  o_valida,
    input  logic                  i_enb,
    input  logic                  i_web,
    input  logic [ADDR_WIDTH-1:0] i_addrb,
    input  logic [DATA_WIDTH-1:0] i_dinb,
    output logic                  o_readyb,
    output logic [DATA_WIDTH-1:0] o_doutb,
    output logic                  o_validb,
    output logic                  o_conflict,
    output logic [15:0]           o_conflict_cnt
);
    localparam int BB    = $clog2(BANK_NO);
    localparam int LW    = ADDR_WIDTH - BB;
    localparam int DEPTH = 1 << LW;
    localparam int RL    = READ_LATENCY;

    logic [DATA_WIDTH-1:0] mem_q [BANK_NO][DEPTH];

    logic                  en     [2];
    logic                  we     [2];
    logic [ADDR_WIDTH-1:0] addr   [2];
    logic [DATA_WIDTH-1:0] din    [2];
    logic [BB-1:0]         bank   [2];
    logic [LW-1:0]         loc    [2];
    logic                  rdy    [2];
    logic                  acc    [2];
    logic [DATA_WIDTH-1:0] rd_dat [2][BANK_NO];

    // Per-port read pipeline: valid, bank tag, and every bank's word at that stage
    logic                  pv_q   [2][RL];
    logic [BB-1:0]         pt_q   [2][RL];
    logic [DATA_WIDTH-1:0] pd_q   [2][RL][BANK_NO];
    logic                  vld_q  [2];
    logic [DATA_WIDTH-1:0] dout_q [2];

    logic        conflict;
    logic        prio_q, prio_d;
    logic        conflict_q;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        en[0]   = i_ena;
        en[1]   = i_enb;
        we[0]   = i_wea;
        we[1]   = i_web;
        addr[0] = i_addra;
        addr[1] = i_addrb;
        din[0]  = i_dina;
        din[1]  = i_dinb;
        for (int p = 0; p < 2; p++) begin
            if (INTERLEAVE != 0) begin
                bank[p] = addr[p][BB-1:0];
                loc[p]  = addr[p][ADDR_WIDTH-1:BB];
            end else begin
                bank[p] = addr[p][ADDR_WIDTH-1 -: BB];
                loc[p]  = addr[p][LW-1:0];
            end
        end
        // Same bank and same local address is exactly address equality
        conflict = en[0] && en[1] && (addr[0] == addr[1]) && (we[0] || we[1]);
        rdy[0]   = i_rst_n && !(conflict && prio_q);
        rdy[1]   = i_rst_n && !(conflict && !prio_q);
        for (int p = 0; p < 2; p++) begin
            acc[p] = en[p] && rdy[p];
            for (int b = 0; b < BANK_NO; b++) begin
                rd_dat[p][b] = mem_q[b][loc[p]];
            end
        end
        prio_d = prio_q ^ conflict;
        cnt_d  = (conflict && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge i_clk) begin
        for (int p = 0; p < 2; p++) begin
            if (acc[p] && we[p]) begin
                mem_q[bank[p]][loc[p]] <= din[p];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int p = 0; p < 2; p++) begin
            if (!i_rst_n) begin
                for (int k = 0; k < RL; k++) begin
                    pv_q[p][k] <= 1'b0;
                end
            end else begin
                pv_q[p][0] <= acc[p] && !we[p];
                for (int k = 1; k < RL; k++) begin
                    pv_q[p][k] <= pv_q[p][k-1];
                end
            end
            pt_q[p][0] <= bank[p];
            for (int b = 0; b < BANK_NO; b++) begin
                pd_q[p][0][b] <= rd_dat[p][b];
            end
            for (int k = 1; k < RL; k++) begin
                pt_q[p][k] <= pt_q[p][k-1];
                for (int b = 0; b < BANK_NO; b++) begin
                    pd_q[p][k][b] <= pd_q[p][k-1][b];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int p = 0; p < 2; p++) begin
            if (!i_rst_n) begin
                vld_q[p]  <= 1'b0;
                dout_q[p] <= '0;
            end else begin
                vld_q[p] <= pv_q[p][RL-1];
                if (pv_q[p][RL-1]) begin
                    dout_q[p] <= pd_q[p][RL-1][pt_q[p][RL-1]];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            prio_q     <= 1'b0;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            prio_q     <= prio_d;
            conflict_q <= conflict;
            cnt_q      <= cnt_d;
        end
    end

    assign o_readya       = rdy[0];
    assign o_readyb       = rdy[1];
    assign o_douta        = dout_q[0];
    assign o_doutb        = dout_q[1];
    assign o_valida       = vld_q[0];
    assign o_validb       = vld_q[1];
    assign o_conflict     = conflict_q;
    assign o_conflict_cnt = cnt_q;

endmodule

// File: tb/tb_multi_bank_ram_arbiter.sv
// Directed bench for multi_bank_ram_arbiter: flat-memory model plus read scoreboard, shared by a top-bit and an interleaved instance.
module tb_multi_bank_ram_arbiter;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int L  = 3;

    typedef struct {
        logic [DW-1:0] dat;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          ena, wea, enb, web;
    logic [AW-1:0] addra, addrb;
    logic [DW-1:0] dina, dinb;

    logic [1:0]    rdya, rdyb, valida, validb, conf;
    logic [DW-1:0] douta [2];
    logic [DW-1:0] doutb [2];
    logic [15:0]   cnt   [2];

    multi_bank_ram_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(L), .BANK_NO(4), .INTERLEAVE(0)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ena(ena), .i_wea(wea), .i_addra(addra), .i_dina(dina),
        .o_readya(rdya[0]), .o_douta(douta[0]), .o_valida(valida[0]),
        .i_enb(enb), .i_web(web), .i_addrb(addrb), .i_dinb(dinb),
        .o_readyb(rdyb[0]), .o_doutb(doutb[0]), .o_validb(validb[0]),
        .o_conflict(conf[0]), .o_conflict_cnt(cnt[0])
    );

    multi_bank_ram_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(L), .BANK_NO(4), .INTERLEAVE(1)
    ) dut_il (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ena(ena), .i_wea(wea), .i_addra(addra), .i_dina(dina),
        .o_readya(rdya[1]), .o_douta(douta[1]), .o_valida(valida[1]),
        .i_enb(enb), .i_web(web), .i_addrb(addrb), .i_dinb(dinb),
        .o_readyb(rdyb[1]), .o_doutb(doutb[1]), .o_validb(validb[1]),
        .o_conflict(conf[1]), .o_conflict_cnt(cnt[1])
    );

    int            n_vec = 0;
    int            n_err = 0;
    int            edge_n = 0;
    logic          chk_en = 1'b0;
    logic [DW-1:0] model [1 << AW];
    exp_t          qa[$];
    exp_t          qb[$];
    logic [DW-1:0] last_a, last_b;
    logic          m_prio, m_conf;
    logic [15:0]   m_cnt;
    logic          acc_a, acc_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one clock: checks readies, records accepts in the model, returns at the next falling edge
    task automatic tick();
        logic c, ra, rb;
        #4;
        c  = rst_n && ena && enb && (addra == addrb) && (wea || web);
        ra = rst_n && !(c && m_prio);
        rb = rst_n && !(c && !m_prio);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("readya_u%0d", i), {31'd0, rdya[i]}, {31'd0, ra});
            chk($sformatf("readyb_u%0d", i), {31'd0, rdyb[i]}, {31'd0, rb});
        end
        acc_a = ena && ra;
        acc_b = enb && rb;
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            m_prio = 1'b0;
            m_conf = 1'b0;
            m_cnt  = 16'd0;
            last_a = '0;
            last_b = '0;
            chk_en = 1'b1;
        end else begin
            if (acc_a && !wea) qa.push_back(exp_t'{model[addra], edge_n + 1 + L});
            if (acc_b && !web) qb.push_back(exp_t'{model[addrb], edge_n + 1 + L});
            if (acc_a && wea) model[addra] = dina;
            if (acc_b && web) model[addrb] = dinb;
            m_conf = c;
            if (c) begin
                m_prio = !m_prio;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
        end
        @(negedge clk);
    endtask

    task automatic go(output int n, output logic [1:0] first);
        n     = 0;
        first = 2'b00;
        while ((ena || enb) && n < 8) begin
            tick();
            n++;
            if (n == 1) first = {acc_a, acc_b};
            if (acc_a) ena = 1'b0;
            if (acc_b) enb = 1'b0;
        end
        chk("accept_timeout", {30'd0, ena, enb}, 32'd0);
    endtask

    task automatic wr_a(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ena = 1'b1; wea = 1'b1; addra = a; dina = d;
    endtask
    task automatic rd_a(input logic [AW-1:0] a);
        ena = 1'b1; wea = 1'b0; addra = a;
    endtask
    task automatic wr_b(input logic [AW-1:0] a, input logic [DW-1:0] d);
        enb = 1'b1; web = 1'b1; addrb = a; dinb = d;
    endtask
    task automatic rd_b(input logic [AW-1:0] a);
        enb = 1'b1; web = 1'b0; addrb = a;
    endtask

    // Output monitor: valid pulses, data hold, and conflict reporting, compared after every rising edge
    initial forever begin
        logic ev_a, ev_b;
        @(posedge clk);
        edge_n++;
        #1;
        if (chk_en) begin
            ev_a = 1'b0;
            ev_b = 1'b0;
            if (qa.size() > 0) begin
                if (qa[0].due == edge_n) begin
                    ev_a   = 1'b1;
                    last_a = qa[0].dat;
                    void'(qa.pop_front());
                end
            end
            if (qb.size() > 0) begin
                if (qb[0].due == edge_n) begin
                    ev_b   = 1'b1;
                    last_b = qb[0].dat;
                    void'(qb.pop_front());
                end
            end
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("valida_u%0d_e%0d", i, edge_n), {31'd0, valida[i]}, {31'd0, ev_a});
                chk($sformatf("douta_u%0d_e%0d", i, edge_n), {24'd0, douta[i]}, {24'd0, last_a});
                chk($sformatf("validb_u%0d_e%0d", i, edge_n), {31'd0, validb[i]}, {31'd0, ev_b});
                chk($sformatf("doutb_u%0d_e%0d", i, edge_n), {24'd0, doutb[i]}, {24'd0, last_b});
                chk($sformatf("conflict_u%0d_e%0d", i, edge_n), {31'd0, conf[i]}, {31'd0, m_conf});
                chk($sformatf("cnt_u%0d_e%0d", i, edge_n), {16'd0, cnt[i]}, {16'd0, m_cnt});
            end
        end
    end

    initial begin
        int            n;
        logic [1:0]    f;
        logic [AW-1:0] tbl [2][4];
        logic [DW-1:0] dtb [2][4];
        tbl[0][0] = 12'h0AA; tbl[0][1] = 12'h4AA; tbl[0][2] = 12'h8AA; tbl[0][3] = 12'hCAA;
        tbl[1][0] = 12'h0A8; tbl[1][1] = 12'h0A9; tbl[1][2] = 12'h0AA; tbl[1][3] = 12'h0AB;
        dtb[0][0] = 8'h11; dtb[0][1] = 8'h22; dtb[0][2] = 8'h33; dtb[0][3] = 8'h44;
        dtb[1][0] = 8'h5A; dtb[1][1] = 8'h6B; dtb[1][2] = 8'h7C; dtb[1][3] = 8'h8D;

        rst_n = 1'b0;
        ena = 1'b0; wea = 1'b0; addra = '0; dina = '0;
        enb = 1'b0; web = 1'b0; addrb = '0; dinb = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Single write, two idle cycles, read back after the full latency
        wr_a(12'h005, 8'hA5); go(n, f);
        tick(); tick();
        rd_a(12'h005); go(n, f);
        repeat (5) tick();

        // One word per bank, then back-to-back reads across banks
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 4; k++) begin
                wr_a(tbl[s][k], dtb[s][k]); go(n, f);
            end
            for (int k = 0; k < 4; k++) begin
                rd_a(tbl[s][k]); go(n, f);
                chk("b2b_single_cycle", n, 32'd1);
            end
            repeat (5) tick();
        end

        // Write-write conflict, A has priority first
        wr_a(12'h123, 8'h55); wr_b(12'h123, 8'h66); go(n, f);
        chk("ww1_cycles", n, 32'd2);
        chk("ww1_first_winner", {30'd0, f}, 32'd2);
        rd_a(12'h123); go(n, f);
        repeat (5) tick();
        chk("ww1_cnt", {16'd0, cnt[0]}, 32'd1);

        // Same conflict again: priority has rotated to B
        wr_a(12'h123, 8'h55); wr_b(12'h123, 8'h66); go(n, f);
        chk("ww2_cycles", n, 32'd2);
        chk("ww2_first_winner", {30'd0, f}, 32'd1);
        rd_b(12'h123); go(n, f);
        repeat (5) tick();
        chk("ww2_cnt", {16'd0, cnt[0]}, 32'd2);

        // Read-read to one address is not a hazard
        wr_a(12'h200, 8'h3C); go(n, f);
        rd_a(12'h200); rd_b(12'h200); go(n, f);
        chk("rr_single_cycle", n, 32'd1);
        repeat (5) tick();

        // Independent writes to different banks proceed together
        wr_a(12'h010, 8'h01); wr_b(12'h810, 8'h02); go(n, f);
        chk("par_single_cycle", n, 32'd1);
        rd_a(12'h010); rd_b(12'h810); go(n, f);
        repeat (5) tick();

        // Reset one edge after a read is accepted: it must vanish; writes during reset are ignored
        rd_a(12'h005); go(n, f);
        rst_n = 1'b0;
        wr_a(12'h005, 8'hEE);
        tick();
        ena = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("rst_cnt", {16'd0, cnt[0]}, 32'd0);
        rd_a(12'h005); rd_b(12'h0AA); go(n, f);
        repeat (5) tick();

        chk("queues_drained", qa.size() + qb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
